// File: rtl/alu_arbiter_pkg.sv
// Shared ALU op encodings and NZCV flag bit positions.
// Imported by the ALU datapath and the two-requester arbiter.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU: ADD/SUB/AND/OR with NZCV.
// Ports: a, b, op in; result, flags {N,Z,C,V} out.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  logic [31:0] bb;
  logic [32:0] sum;
  logic        sub;

  // SUB reuses the adder as a + ~b + 1
  assign sub = (op == OP_SUB);
  assign bb  = sub ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bb} + {32'd0, sub};

  always_comb begin
    result = '0;
    flags  = '0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        result        = sum[31:0];
        flags[FLAG_C] = sum[32];
        flags[FLAG_V] = (a[31] == bb[31])
                      && (sum[31] != a[31]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      default: result = '0;
    endcase
    flags[FLAG_N] = result[31];
    flags[FLAG_Z] = (result == 32'd0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters time-share one ALU; one-entry response buffer.
// Ports: reqN_* handshake/operands, rsp_* output, sticky flagsN.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int PRIO_FIXED = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req0_op,
  input  logic [1:0]  req1_op,
  input  logic        req0_setf,
  input  logic        req1_setf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_src,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [3:0]  flags0,
  output logic [3:0]  flags1
);

  logic        acc_en;
  logic        gnt;
  logic        last;
  logic        hs;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  alu_op_e     alu_op;
  logic [31:0] alu_res;
  logic [3:0]  alu_fl;

  assign acc_en = !rsp_valid || rsp_ready;

  // last==1 after reset so requester 0 wins first contention
  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      req0_valid && req1_valid:
        gnt = (PRIO_FIXED != 0) ? 1'b0 : ~last;
      req1_valid && !req0_valid:
        gnt = 1'b1;
      default:
        gnt = 1'b0;
    endcase
  end

  assign req0_ready = acc_en && req0_valid && !gnt;
  assign req1_ready = acc_en && req1_valid && gnt;
  assign hs = req0_ready || req1_ready;

  assign alu_a  = gnt ? req1_a : req0_a;
  assign alu_b  = gnt ? req1_b : req0_b;
  assign alu_op = alu_op_e'(gnt ? req1_op : req0_op);

  alu_arbiter_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .flags  (alu_fl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_src    <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      flags0     <= '0;
      flags1     <= '0;
      last       <= 1'b1;
    end else if (hs) begin
      rsp_valid  <= 1'b1;
      rsp_src    <= gnt;
      rsp_result <= alu_res;
      rsp_flags  <= alu_fl;
      last       <= gnt;
      if (req0_ready && req0_setf) flags0 <= alu_fl;
      if (req1_ready && req1_setf) flags1 <= alu_fl;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus
// round-robin, backpressure and reset sequences.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        req0_setf, req1_setf;
  logic        rsp_valid, rsp_ready, rsp_src;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags, flags0, flags1;

  logic        fx_r0, fx_r1, fx_v, fx_src;
  logic [31:0] fx_res;
  logic [3:0]  fx_fl, fx_f0, fx_f1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.PRIO_FIXED(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_setf(req0_setf), .req1_setf(req1_setf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_src(rsp_src), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags),
    .flags0(flags0), .flags1(flags1)
  );

  alu_arbiter #(.PRIO_FIXED(1)) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(fx_r0), .req1_ready(fx_r1),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_setf(req0_setf), .req1_setf(req1_setf),
    .rsp_valid(fx_v), .rsp_ready(1'b1),
    .rsp_src(fx_src), .rsp_result(fx_res),
    .rsp_flags(fx_fl),
    .flags0(fx_f0), .flags1(fx_f1)
  );

  typedef struct {
    logic        src;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        setf;
    logic [31:0] res;
    logic [3:0]  fl;
    logic [3:0]  f0;
    logic [3:0]  f1;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    req0_op = 0; req1_op = 0;
    req0_setf = 0; req1_setf = 0;
  endtask

  initial begin
    vt[0] = '{1'b0, 2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b1,
              32'h80000000, 4'b1001, 4'b1001, 4'b0000};
    vt[1] = '{1'b1, 2'b01, 32'h00000005, 32'h00000005, 1'b1,
              32'h00000000, 4'b0110, 4'b1001, 4'b0110};
    vt[2] = '{1'b0, 2'b10, 32'hF0000000, 32'h80000000, 1'b0,
              32'h80000000, 4'b1000, 4'b1001, 4'b0110};
    vt[3] = '{1'b1, 2'b11, 32'h000000F0, 32'h0000000F, 1'b1,
              32'h000000FF, 4'b0000, 4'b1001, 4'b0000};
    vt[4] = '{1'b0, 2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b1,
              32'h00000000, 4'b0110, 4'b0110, 4'b0000};
    vt[5] = '{1'b1, 2'b01, 32'h00000000, 32'h00000001, 1'b0,
              32'hFFFFFFFF, 4'b1000, 4'b0110, 4'b0000};
    vt[6] = '{1'b0, 2'b01, 32'h80000000, 32'h00000001, 1'b1,
              32'h7FFFFFFF, 4'b0011, 4'b0011, 4'b0000};
    vt[7] = '{1'b1, 2'b10, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1,
              32'h00000000, 4'b0100, 4'b0011, 4'b0100};

    idle();
    rsp_ready = 1'b1;
    do_reset();
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_src", rsp_src, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_flags", rsp_flags, 0);
    chk("rst_f0", flags0, 0);
    chk("rst_f1", flags1, 0);

    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (vt[i].src) begin
        req1_valid = 1; req1_op = vt[i].op;
        req1_a = vt[i].a; req1_b = vt[i].b;
        req1_setf = vt[i].setf;
      end else begin
        req0_valid = 1; req0_op = vt[i].op;
        req0_a = vt[i].a; req0_b = vt[i].b;
        req0_setf = vt[i].setf;
      end
      #1;
      chk($sformatf("v%0d_ready", i),
          vt[i].src ? req1_ready : req0_ready, 1);
      @(posedge clk); #1;
      idle();
      chk($sformatf("v%0d_valid", i), rsp_valid, 1);
      chk($sformatf("v%0d_src", i), rsp_src, vt[i].src);
      chk($sformatf("v%0d_res", i), rsp_result, vt[i].res);
      chk($sformatf("v%0d_flags", i), rsp_flags, vt[i].fl);
      chk($sformatf("v%0d_f0", i), flags0, vt[i].f0);
      chk($sformatf("v%0d_f1", i), flags1, vt[i].f1);
    end
    @(posedge clk); #1;
    chk("drain_valid", rsp_valid, 0);

    // round robin: both valid, no bubbles
    do_reset();
    req0_valid = 1; req0_a = 1;  req0_b = 2;
    req1_valid = 1; req1_a = 10; req1_b = 20;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_r0", i), req0_ready, (i % 2) == 0);
      chk($sformatf("rr%0d_r1", i), req1_ready, (i % 2) == 1);
      chk($sformatf("fx%0d_r0", i), fx_r0, 1);
      chk($sformatf("fx%0d_r1", i), fx_r1, 0);
      @(posedge clk); #1;
      chk($sformatf("rr%0d_valid", i), rsp_valid, 1);
      chk($sformatf("rr%0d_src", i), rsp_src, i % 2);
      chk($sformatf("rr%0d_res", i), rsp_result,
          (i % 2) ? 32'd30 : 32'd3);
    end

    // backpressure: response from req1 held for 3 cycles
    rsp_ready = 0;
    req0_a = 5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d_r0", i), req0_ready, 0);
      chk($sformatf("bp%0d_r1", i), req1_ready, 0);
      chk($sformatf("bp%0d_valid", i), rsp_valid, 1);
      chk($sformatf("bp%0d_src", i), rsp_src, 1);
      chk($sformatf("bp%0d_res", i), rsp_result, 30);
      chk($sformatf("bp%0d_fl", i), rsp_flags, 0);
      @(posedge clk);
    end
    #1 rsp_ready = 1;
    #1;
    chk("bp_rel_r0", req0_ready, 1);
    chk("bp_rel_r1", req1_ready, 0);
    @(posedge clk); #1;
    idle();
    chk("bp_rel_valid", rsp_valid, 1);
    chk("bp_rel_src", rsp_src, 0);
    chk("bp_rel_res", rsp_result, 7);
    @(posedge clk); #1;
    chk("bp_drop_valid", rsp_valid, 0);

    // reset while a response is held
    req0_valid = 1; req0_op = 2'b01;
    req0_a = 0; req0_b = 1; req0_setf = 1;
    req1_valid = 1; req1_op = 2'b00;
    req1_a = 32'h7FFFFFFF; req1_b = 1; req1_setf = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle();
    rsp_ready = 0;
    chk("mr_pre_valid", rsp_valid, 1);
    chk("mr_pre_f1", flags1, 4'b1001);
    chk("mr_pre_f0", flags0, 4'b1000);
    rst_n = 0;
    #1;
    chk("mr_valid", rsp_valid, 0);
    chk("mr_flags", rsp_flags, 0);
    chk("mr_res", rsp_result, 0);
    chk("mr_f0", flags0, 0);
    chk("mr_f1", flags1, 0);
    @(posedge clk); #1 rst_n = 1;
    rsp_ready = 1;
    @(posedge clk); #1;
    chk("mr_noreplay", rsp_valid, 0);
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("mr_gnt_r0", req0_ready, 1);
    chk("mr_gnt_r1", req1_ready, 0);
    @(posedge clk); #1;
    idle();
    chk("mr_gnt_src", rsp_src, 0);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter PRIO_FIXED, default 0: 0 = round-robin arbitration, 1 = requester 0 always wins.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have ports req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 The block SHALL have ports req0_ready / req1_ready  output  1  operation of requester N is accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  32  operands.
REQ-007 The block SHALL have ports req0_op / req1_op  input  2  ALU control code: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-008 The block SHALL have ports req0_setf / req1_setf  input  1  update that requester's flag register on acceptance.
REQ-009 The block SHALL have port rsp_valid  output  1  response register holds a result.
REQ-010 The block SHALL have port rsp_ready  input  1  consumer takes the response.
REQ-011 The block SHALL have port rsp_src  output  1  requester index of the held response.
REQ-012 The block SHALL have port rsp_result  output  32  registered ALU result.
REQ-013 The block SHALL have port rsp_flags  output  4  registered {N,Z,C,V} of that operation.
REQ-014 The block SHALL have ports flags0 / flags1  output  4  per-requester sticky NZCV status registers.

Function
REQ-015 A single shared ALU instance SHALL be time-shared; only the granted requester's a, b, op reach it.
REQ-016 Accept enable SHALL be acc_en = !rsp_valid || rsp_ready (one-entry output buffer, full throughput, one op per cycle).
REQ-017 reqN_ready SHALL be high only when acc_en is high and requester N is granted; it may depend combinationally on reqN_valid.
REQ-018 A handshake SHALL occur when reqN_valid && reqN_ready; at most one per cycle.
REQ-019 With one requester valid, that requester SHALL be granted.
REQ-020 With both valid and PRIO_FIXED=0, the requester not granted last SHALL win; the last-grant pointer updates only on a handshake.
REQ-021 With both valid and PRIO_FIXED=1, requester 0 SHALL win.
REQ-022 Latency SHALL be exactly one cycle: the handshake in cycle T gives rsp_valid=1 with result/flags/src in cycle T+1.
REQ-023 While rsp_valid && !rsp_ready, rsp_src, rsp_result and rsp_flags SHALL hold stable and both reqN_ready SHALL be 0.
REQ-024 When rsp_ready is high with no new handshake, rsp_valid SHALL drop next cycle; when a handshake coincides, rsp_valid SHALL stay high with the new data.
REQ-025 For AND/OR, C and V SHALL be 0; N = result[31]; Z = (result == 0).
REQ-026 For ADD/SUB, C SHALL be the 33rd sum bit (SUB = a + ~b + 1) and V SHALL be signed overflow.
REQ-027 flagsN SHALL load the operation's NZCV in cycle T+1 only if reqN_setf was high at the handshake; otherwise it holds.
REQ-028 Operand or op changes while reqN_ready=0 SHALL have no effect.

Reset
REQ-029 On rst_n low the block SHALL asynchronously force rsp_valid=0, rsp_src=0, rsp_result=0, rsp_flags=0, flags0=flags1=0, with the last-grant pointer set so requester 0 wins the first contention.
REQ-030 Reset mid-operation SHALL discard the held response and any in-flight handshake; nothing is replayed after rst_n rises.

Structure
REQ-031 A shared package SHALL hold the op encodings (ADD, SUB, AND, OR) and the NZCV bit indices (N=3, Z=2, C=1, V=0).
REQ-032 The block SHALL instantiate the existing alu datapath module as its single sub-module; no arithmetic is duplicated.

Verification
REQ-033 req0 ADD 0x7FFFFFFF+0x00000001, setf=1 -> next cycle rsp_result 0x80000000, rsp_flags 4'b1001, flags0 4'b1001, rsp_src 0.
REQ-034 req1 SUB 0x00000005-0x00000005, setf=1 -> rsp_result 0x00000000, rsp_flags 4'b0110, flags1 4'b0110, flags0 unchanged.
REQ-035 Both valid for 4 cycles after reset, rsp_ready=1, PRIO_FIXED=0 -> grants 0,1,0,1; rsp_src sequence 0,1,0,1 with no bubbles.
REQ-036 rsp_ready=0 for 3 cycles with a response held -> rsp_* stable, req0_ready=req1_ready=0; on rsp_ready=1 the waiting requester is accepted the same cycle.
REQ-037 req0 AND 0xF0000000 & 0x80000000, setf=0 -> rsp_result 0x80000000, rsp_flags 4'b1000, flags0 unchanged.
REQ-038 rst_n pulsed low while rsp_valid=1 -> rsp_valid, rsp_flags, flags0 and flags1 read 0 immediately; first post-reset contention grants req0.
